// File: rtl/bp_be_issue_ckpt_fifo_pkg.sv
// Shared types and constants for the BE issue checkpoint FIFO: FE queue message
// layout, predecoded issue packet, and the RISC-V major opcodes the predecoder inspects.
package bp_be_issue_ckpt_fifo_pkg;

  localparam int unsigned vaddr_width_p               = 39;
  localparam int unsigned branch_metadata_fwd_width_p = 16;
  localparam int unsigned instr_width_gp              = 32;
  localparam int unsigned reg_addr_width_gp           = 5;

  typedef enum logic [0:0] {
    e_fe_fetch     = 1'b0,
    e_fe_exception = 1'b1
  } bp_fe_queue_type_e;

  typedef enum logic [1:0] {
    e_instr_misaligned   = 2'd0,
    e_instr_access_fault = 2'd1,
    e_instr_page_fault   = 2'd2,
    e_itlb_miss          = 2'd3
  } bp_fe_exception_e;

  typedef struct packed {
    bp_fe_queue_type_e                      msg_type;
    bp_fe_exception_e                       exc;
    logic [vaddr_width_p-1:0]               pc;
    logic [instr_width_gp-1:0]              instr;
    logic [branch_metadata_fwd_width_p-1:0] branch_metadata_fwd;
  } bp_fe_queue_s;

  localparam int unsigned fe_queue_width_lp = $bits(bp_fe_queue_s);

  typedef struct packed {
    logic [reg_addr_width_gp-1:0] rs1_addr;
    logic [reg_addr_width_gp-1:0] rs2_addr;
    logic [reg_addr_width_gp-1:0] rs3_addr;
    logic [reg_addr_width_gp-1:0] rd_addr;
    logic                         irs1_v;
    logic                         irs2_v;
    logic                         frs1_v;
    logic                         frs2_v;
    logic                         frs3_v;
    logic                         fence_v;
    logic                         csr_w_v;
    logic                         mem_v;
    logic                         long_v;
  } bp_be_issue_pkt_s;

  localparam int unsigned issue_pkt_width_lp = $bits(bp_be_issue_pkt_s);

  localparam logic [6:0] opcode_load_gp     = 7'b0000011;
  localparam logic [6:0] opcode_load_fp_gp  = 7'b0000111;
  localparam logic [6:0] opcode_misc_mem_gp = 7'b0001111;
  localparam logic [6:0] opcode_op_imm_gp   = 7'b0010011;
  localparam logic [6:0] opcode_op_imm32_gp = 7'b0011011;
  localparam logic [6:0] opcode_store_gp    = 7'b0100011;
  localparam logic [6:0] opcode_store_fp_gp = 7'b0100111;
  localparam logic [6:0] opcode_amo_gp      = 7'b0101111;
  localparam logic [6:0] opcode_op_gp       = 7'b0110011;
  localparam logic [6:0] opcode_op32_gp     = 7'b0111011;
  localparam logic [6:0] opcode_fmadd_gp    = 7'b1000011;
  localparam logic [6:0] opcode_fmsub_gp    = 7'b1000111;
  localparam logic [6:0] opcode_fnmsub_gp   = 7'b1001011;
  localparam logic [6:0] opcode_fnmadd_gp   = 7'b1001111;
  localparam logic [6:0] opcode_op_fp_gp    = 7'b1010011;
  localparam logic [6:0] opcode_branch_gp   = 7'b1100011;
  localparam logic [6:0] opcode_jalr_gp     = 7'b1100111;
  localparam logic [6:0] opcode_system_gp   = 7'b1110011;

  localparam logic [6:0] funct7_muldiv_gp = 7'b0000001;

  // OP-FP funct5 groups
  localparam logic [4:0] fp_f5_add_gp    = 5'h00;
  localparam logic [4:0] fp_f5_sub_gp    = 5'h01;
  localparam logic [4:0] fp_f5_mul_gp    = 5'h02;
  localparam logic [4:0] fp_f5_div_gp    = 5'h03;
  localparam logic [4:0] fp_f5_sgnj_gp   = 5'h04;
  localparam logic [4:0] fp_f5_minmax_gp = 5'h05;
  localparam logic [4:0] fp_f5_cvtff_gp  = 5'h08;
  localparam logic [4:0] fp_f5_sqrt_gp   = 5'h0b;
  localparam logic [4:0] fp_f5_cmp_gp    = 5'h14;
  localparam logic [4:0] fp_f5_cvtfi_gp  = 5'h18;
  localparam logic [4:0] fp_f5_cvtif_gp  = 5'h1a;
  localparam logic [4:0] fp_f5_mvxf_gp   = 5'h1c;
  localparam logic [4:0] fp_f5_mvfx_gp   = 5'h1e;

endpackage

// File: rtl/bp_be_issue_ckpt_fifo_if.sv
// FE-queue / scheduler bundle for the issue checkpoint FIFO; signal names are
// from the FIFO's point of view.
interface bp_be_issue_ckpt_fifo_if;
  import bp_be_issue_ckpt_fifo_pkg::*;

  bp_fe_queue_s     fe_queue_i;
  logic             fe_queue_v_i;
  logic             fe_queue_ready_o;
  bp_fe_queue_s     fe_queue_o;
  logic             fe_queue_v_o;
  logic             fe_queue_yumi_i;
  bp_be_issue_pkt_s preissue_pkt_o;
  bp_be_issue_pkt_s issue_pkt_o;
  logic             clr_v_i;
  logic             deq_v_i;
  logic             roll_v_i;

  modport slave (
    input  fe_queue_i, fe_queue_v_i, fe_queue_yumi_i, clr_v_i, deq_v_i, roll_v_i,
    output fe_queue_ready_o, fe_queue_o, fe_queue_v_o, preissue_pkt_o, issue_pkt_o
  );

  modport master (
    output fe_queue_i, fe_queue_v_i, fe_queue_yumi_i, clr_v_i, deq_v_i, roll_v_i,
    input  fe_queue_ready_o, fe_queue_o, fe_queue_v_o, preissue_pkt_o, issue_pkt_o
  );

endinterface

// File: rtl/bp_be_issue_ckpt_fifo_predecode.sv
// Combinational predecode of one instruction into register-read and class flags.
// Non-fetch messages produce an all-zero packet.
module bp_be_issue_ckpt_fifo_predecode
  import bp_be_issue_ckpt_fifo_pkg::*;
(
  input  logic                      fetch_v_i,
  input  logic [instr_width_gp-1:0] instr_i,
  output bp_be_issue_pkt_s          issue_pkt_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] funct5;
  logic [6:0] funct7;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct5 = instr_i[31:27];
  assign funct7 = instr_i[31:25];

  always_comb begin
    issue_pkt_o = '0;
    if (fetch_v_i) begin
      issue_pkt_o.rs1_addr = instr_i[19:15];
      issue_pkt_o.rs2_addr = instr_i[24:20];
      issue_pkt_o.rs3_addr = instr_i[31:27];
      issue_pkt_o.rd_addr  = instr_i[11:7];
      case (opcode)
        opcode_op_gp, opcode_op32_gp: begin
          issue_pkt_o.irs1_v = 1'b1;
          issue_pkt_o.irs2_v = 1'b1;
          issue_pkt_o.long_v = (funct7 == funct7_muldiv_gp);
        end
        opcode_op_imm_gp, opcode_op_imm32_gp, opcode_jalr_gp: begin
          issue_pkt_o.irs1_v = 1'b1;
        end
        opcode_load_gp: begin
          issue_pkt_o.irs1_v = 1'b1;
          issue_pkt_o.mem_v  = 1'b1;
        end
        opcode_store_gp, opcode_amo_gp: begin
          issue_pkt_o.irs1_v = 1'b1;
          issue_pkt_o.irs2_v = 1'b1;
          issue_pkt_o.mem_v  = 1'b1;
        end
        opcode_branch_gp: begin
          issue_pkt_o.irs1_v = 1'b1;
          issue_pkt_o.irs2_v = 1'b1;
        end
        opcode_load_fp_gp: begin
          issue_pkt_o.irs1_v = 1'b1;
          issue_pkt_o.mem_v  = 1'b1;
        end
        opcode_store_fp_gp: begin
          issue_pkt_o.irs1_v = 1'b1;
          issue_pkt_o.frs2_v = 1'b1;
          issue_pkt_o.mem_v  = 1'b1;
        end
        opcode_fmadd_gp, opcode_fmsub_gp, opcode_fnmsub_gp, opcode_fnmadd_gp: begin
          issue_pkt_o.frs1_v = 1'b1;
          issue_pkt_o.frs2_v = 1'b1;
          issue_pkt_o.frs3_v = 1'b1;
        end
        opcode_misc_mem_gp: begin
          issue_pkt_o.fence_v = 1'b1;
        end
        opcode_system_gp: begin
          // funct3 0 is ECALL/EBREAK/xRET; only the register CSR forms read rs1
          issue_pkt_o.csr_w_v = (funct3 != 3'b000);
          issue_pkt_o.irs1_v  = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b011);
        end
        opcode_op_fp_gp: begin
          case (funct5)
            fp_f5_add_gp, fp_f5_sub_gp, fp_f5_mul_gp, fp_f5_sgnj_gp, fp_f5_minmax_gp,
            fp_f5_cmp_gp: begin
              issue_pkt_o.frs1_v = 1'b1;
              issue_pkt_o.frs2_v = 1'b1;
            end
            fp_f5_div_gp: begin
              issue_pkt_o.frs1_v = 1'b1;
              issue_pkt_o.frs2_v = 1'b1;
              issue_pkt_o.long_v = 1'b1;
            end
            fp_f5_sqrt_gp: begin
              issue_pkt_o.frs1_v = 1'b1;
              issue_pkt_o.long_v = 1'b1;
            end
            fp_f5_cvtff_gp, fp_f5_cvtfi_gp, fp_f5_mvxf_gp: begin
              issue_pkt_o.frs1_v = 1'b1;
            end
            fp_f5_cvtif_gp, fp_f5_mvfx_gp: begin
              issue_pkt_o.irs1_v = 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/bp_be_issue_ckpt_fifo.sv
// Checkpointed FE->BE queue: speculative read pointer for issue, commit pointer for
// retire, rollback/clear support, and one-cycle-early predecode for register reads.
module bp_be_issue_ckpt_fifo
  import bp_be_issue_ckpt_fifo_pkg::*;
#(
  parameter int unsigned els_p = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  bp_be_issue_ckpt_fifo_if.slave  fifo_io
);

  localparam int unsigned addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int unsigned ptr_width_lp  = addr_width_lp + 1;

  typedef logic [ptr_width_lp-1:0] ptr_t;

  typedef struct packed {
    bp_fe_queue_s     msg;
    bp_be_issue_pkt_s pkt;
  } entry_s;

  ptr_t wptr_q, wptr_d;
  ptr_t rptr_q, rptr_d;
  ptr_t cptr_q, cptr_d;

  entry_s           mem_q [els_p];
  bp_be_issue_pkt_s enq_pkt;
  bp_be_issue_pkt_s byp_pkt;
  bp_be_issue_pkt_s preissue_pkt;
  bp_be_issue_pkt_s issue_pkt_q;

  logic full;
  logic enq;
  logic enq_write;

  // Wrap bit distinguishes full from empty when the index bits match
  assign full = (wptr_q[ptr_width_lp-1] != cptr_q[ptr_width_lp-1])
             && (wptr_q[addr_width_lp-1:0] == cptr_q[addr_width_lp-1:0]);

  assign enq       = fifo_io.fe_queue_v_i & ~full;
  assign enq_write = enq & ~fifo_io.clr_v_i;

  bp_be_issue_ckpt_fifo_predecode u_enq_predecode (
    .fetch_v_i   (fifo_io.fe_queue_i.msg_type == e_fe_fetch),
    .instr_i     (fifo_io.fe_queue_i.instr),
    .issue_pkt_o (enq_pkt)
  );

  // Separate copy on the bypass path keeps it off the storage write fanout
  bp_be_issue_ckpt_fifo_predecode u_byp_predecode (
    .fetch_v_i   (fifo_io.fe_queue_i.msg_type == e_fe_fetch),
    .instr_i     (fifo_io.fe_queue_i.instr),
    .issue_pkt_o (byp_pkt)
  );

  always_comb begin
    cptr_d = cptr_q + ptr_t'(fifo_io.deq_v_i);
    wptr_d = wptr_q + ptr_t'(enq);
    rptr_d = rptr_q + ptr_t'(fifo_io.fe_queue_yumi_i);
    if (fifo_io.clr_v_i) begin
      wptr_d = cptr_d;
      rptr_d = cptr_d;
    end else if (fifo_io.roll_v_i) begin
      rptr_d = cptr_d;
    end
  end

  always_comb begin
    preissue_pkt = mem_q[rptr_d[addr_width_lp-1:0]].pkt;
    if (reset_i) begin
      preissue_pkt = '0;
    end else if (enq_write && (rptr_d == wptr_q)) begin
      preissue_pkt = byp_pkt;
    end else if (rptr_d == wptr_d) begin
      preissue_pkt = '0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      cptr_q      <= '0;
      issue_pkt_q <= '0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cptr_q      <= cptr_d;
      issue_pkt_q <= preissue_pkt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq_write) begin
      mem_q[wptr_q[addr_width_lp-1:0]] <= '{msg: fifo_io.fe_queue_i, pkt: enq_pkt};
    end
  end

  assign fifo_io.fe_queue_ready_o = ~full;
  assign fifo_io.fe_queue_v_o     = (rptr_q != wptr_q);
  assign fifo_io.fe_queue_o       = mem_q[rptr_q[addr_width_lp-1:0]].msg;
  assign fifo_io.preissue_pkt_o   = preissue_pkt;
  assign fifo_io.issue_pkt_o      = issue_pkt_q;

endmodule

// File: tb/tb_bp_be_issue_ckpt_fifo.sv
// Directed and randomized bench for the issue checkpoint FIFO, checked against a
// queue model of committed/issued/pending entries.
module tb_bp_be_issue_ckpt_fifo;
  import bp_be_issue_ckpt_fifo_pkg::*;

  localparam int unsigned Els = 8;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  // Model: mq holds every uncommitted entry, oldest first; spec counts issued ones
  bp_fe_queue_s mq[$];
  int           spec;

  logic [6:0] ops [21] = '{7'h03, 7'h07, 7'h0f, 7'h13, 7'h17, 7'h1b, 7'h23, 7'h27, 7'h2f,
                           7'h33, 7'h37, 7'h3b, 7'h43, 7'h47, 7'h4b, 7'h4f, 7'h53, 7'h63,
                           7'h67, 7'h6f, 7'h73};

  bp_be_issue_ckpt_fifo_if fifo_if ();

  bp_be_issue_ckpt_fifo #(
    .els_p (Els)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .fifo_io (fifo_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Register-use rules per instruction class, one flag at a time
  function automatic bp_be_issue_pkt_s ref_pred(input bp_fe_queue_s m);
    bp_be_issue_pkt_s p;
    logic [31:0] i;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  f5;
    logic        fma;
    p = '0;
    if (m.msg_type == e_fe_fetch) begin
      i  = m.instr;
      op = i[6:0];
      f3 = i[14:12];
      f5 = i[31:27];
      fma = op inside {7'h43, 7'h47, 7'h4b, 7'h4f};
      p.rd_addr  = i[11:7];
      p.rs1_addr = i[19:15];
      p.rs2_addr = i[24:20];
      p.rs3_addr = i[31:27];
      p.irs1_v  = (op inside {7'h33, 7'h3b, 7'h13, 7'h1b, 7'h03, 7'h23, 7'h63, 7'h67, 7'h2f,
                              7'h07, 7'h27})
               || (op == 7'h73 && f3 inside {3'd1, 3'd2, 3'd3})
               || (op == 7'h53 && f5 inside {5'h1a, 5'h1e});
      p.irs2_v  = op inside {7'h33, 7'h3b, 7'h23, 7'h63, 7'h2f};
      p.frs1_v  = fma || (op == 7'h53 && f5 inside {5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05,
                                                   5'h14, 5'h0b, 5'h08, 5'h18, 5'h1c});
      p.frs2_v  = fma || (op == 7'h27)
               || (op == 7'h53 && f5 inside {5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h14});
      p.frs3_v  = fma;
      p.mem_v   = op inside {7'h03, 7'h23, 7'h2f, 7'h07, 7'h27};
      p.fence_v = (op == 7'h0f);
      p.csr_w_v = (op == 7'h73) && (f3 != 3'd0);
      p.long_v  = (op inside {7'h33, 7'h3b} && i[31:25] == 7'h01)
               || (op == 7'h53 && f5 inside {5'h03, 5'h0b});
    end
    return p;
  endfunction

  function automatic bp_fe_queue_s mk_fetch(input logic [31:0] instr);
    bp_fe_queue_s m;
    m.msg_type            = e_fe_fetch;
    m.exc                 = e_instr_misaligned;
    m.pc                  = vaddr_width_p'({$urandom, $urandom});
    m.instr               = instr;
    m.branch_metadata_fwd = branch_metadata_fwd_width_p'($urandom);
    return m;
  endfunction

  function automatic bp_fe_queue_s mk_rand();
    logic [31:0] instr;
    instr      = $urandom;
    instr[6:0] = ops[$urandom_range(0, 20)];
    return mk_fetch(instr);
  endfunction

  function automatic bp_fe_queue_s mk_exc();
    bp_fe_queue_s m;
    m          = mk_fetch($urandom);
    m.msg_type = e_fe_exception;
    m.exc      = e_instr_page_fault;
    return m;
  endfunction

  // Called just after a rising edge: drive, check at the falling edge, advance model
  task automatic do_cycle(input logic enq_v, input bp_fe_queue_s msg, input logic yumi,
                          input logic deq, input logic roll, input logic clr);
    bp_fe_queue_s     nq[$];
    int               ns;
    logic             v;
    bp_be_issue_pkt_s exp_pre;
    bp_be_issue_pkt_s exp_iss;
    assert (!deq || spec > 0) else begin
      failures++;
      $error("FAIL deq_legal: observed=deq with cptr==rptr expected=no deq");
    end
    fifo_if.fe_queue_v_i    = enq_v;
    fifo_if.fe_queue_i      = msg;
    fifo_if.fe_queue_yumi_i = yumi;
    fifo_if.deq_v_i         = deq;
    fifo_if.roll_v_i        = roll;
    fifo_if.clr_v_i         = clr;
    nq = mq;
    ns = spec;
    if (deq) begin
      void'(nq.pop_front());
      ns--;
    end
    if (clr) begin
      nq.delete();
      ns = 0;
    end else begin
      if (enq_v && mq.size() < Els) nq.push_back(msg);
      if (roll) ns = 0;
      else if (yumi) ns++;
    end
    exp_pre = '0;
    if (ns < nq.size()) exp_pre = ref_pred(nq[ns]);
    v       = (spec < mq.size());
    exp_iss = '0;
    if (v) exp_iss = ref_pred(mq[spec]);
    @(negedge clk);
    chk("ready", fifo_if.fe_queue_ready_o, mq.size() < Els);
    chk("v_o", fifo_if.fe_queue_v_o, v);
    if (v) chk("head", fifo_if.fe_queue_o, mq[spec]);
    chk("issue_pkt", fifo_if.issue_pkt_o, exp_iss);
    chk("preissue_pkt", fifo_if.preissue_pkt_o, exp_pre);
    @(posedge clk);
    #1;
    mq   = nq;
    spec = ns;
    fifo_if.fe_queue_v_i    = 1'b0;
    fifo_if.fe_queue_yumi_i = 1'b0;
    fifo_if.deq_v_i         = 1'b0;
    fifo_if.roll_v_i        = 1'b0;
    fifo_if.clr_v_i         = 1'b0;
  endtask

  task automatic idle();
    do_cycle(1'b0, mk_rand(), 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bp_fe_queue_s add_m, ld_m, fadd_m, m1;
    checks   = 0;
    failures = 0;
    spec     = 0;
    reset    = 1'b1;
    fifo_if.fe_queue_i      = '0;
    fifo_if.fe_queue_v_i    = 1'b0;
    fifo_if.fe_queue_yumi_i = 1'b0;
    fifo_if.deq_v_i         = 1'b0;
    fifo_if.roll_v_i        = 1'b0;
    fifo_if.clr_v_i         = 1'b0;
    #2;
    chk("rst_v_o", fifo_if.fe_queue_v_o, 1'b0);
    chk("rst_ready", fifo_if.fe_queue_ready_o, 1'b1);
    chk("rst_issue", fifo_if.issue_pkt_o, '0);
    chk("rst_preissue", fifo_if.preissue_pkt_o, '0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // ADD x3,x1,x2 / LD x5,0(x6) / FADD.D f1,f2,f3; first one bypasses into preissue
    add_m  = mk_fetch(32'h002081B3);
    ld_m   = mk_fetch(32'h00033283);
    fadd_m = mk_fetch(32'h023170D3);
    do_cycle(1'b1, add_m, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("add_issue_rs1", fifo_if.issue_pkt_o.rs1_addr, 5'd1);
    chk("add_issue_irs", {fifo_if.issue_pkt_o.irs1_v, fifo_if.issue_pkt_o.irs2_v}, 2'b11);
    do_cycle(1'b1, ld_m, 1'b0, 1'b0, 1'b0, 1'b0);
    do_cycle(1'b1, fadd_m, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();

    // Fill to 8, issue all with blocked enqueue attempts, one commit reopens space
    for (int n = 0; n < 5; n++) do_cycle(1'b1, mk_rand(), 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    for (int n = 0; n < 8; n++) do_cycle(1'b1, mk_rand(), 1'b1, 1'b0, 1'b0, 1'b0);
    do_cycle(1'b0, mk_rand(), 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    for (int n = 0; n < 7; n++) do_cycle(1'b0, mk_rand(), 1'b0, 1'b1, 1'b0, 1'b0);
    idle();

    // Enqueue 4, issue 3, commit 1, roll back to the second message
    do_cycle(1'b1, mk_rand(), 1'b0, 1'b0, 1'b0, 1'b0);
    m1 = mk_rand();
    do_cycle(1'b1, m1, 1'b0, 1'b0, 1'b0, 1'b0);
    do_cycle(1'b1, mk_rand(), 1'b0, 1'b0, 1'b0, 1'b0);
    do_cycle(1'b1, mk_rand(), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 3; n++) do_cycle(1'b0, mk_rand(), 1'b1, 1'b0, 1'b0, 1'b0);
    do_cycle(1'b0, mk_rand(), 1'b0, 1'b1, 1'b0, 1'b0);
    do_cycle(1'b0, mk_rand(), 1'b0, 1'b0, 1'b1, 1'b0);
    chk("roll_head", fifo_if.fe_queue_o, m1);
    idle();

    // Roll together with yumi and deq: rptr lands on cptr+1
    do_cycle(1'b0, mk_rand(), 1'b1, 1'b0, 1'b0, 1'b0);
    do_cycle(1'b0, mk_rand(), 1'b1, 1'b1, 1'b1, 1'b0);
    idle();

    // Clear with a simultaneous enqueue and commit
    do_cycle(1'b1, mk_rand(), 1'b0, 1'b0, 1'b0, 1'b0);
    do_cycle(1'b1, mk_rand(), 1'b1, 1'b0, 1'b0, 1'b0);
    do_cycle(1'b1, mk_rand(), 1'b1, 1'b1, 1'b0, 1'b0);
    do_cycle(1'b1, mk_rand(), 1'b0, 1'b1, 1'b1, 1'b1);
    idle();
    idle();

    // Exception message at head predecodes to nothing
    do_cycle(1'b1, mk_exc(), 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    chk("exc_issue_zero", fifo_if.issue_pkt_o, '0);
    do_cycle(1'b0, mk_rand(), 1'b1, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 1500; n++) begin
      logic e, y, d, r, c;
      bp_fe_queue_s m;
      e = ($urandom_range(0, 2) != 0);
      m = ($urandom_range(0, 9) == 0) ? mk_exc() : mk_rand();
      y = (spec < mq.size()) && ($urandom_range(0, 1) == 1);
      d = (spec > 0) && ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 19) == 0);
      c = ($urandom_range(0, 39) == 0);
      do_cycle(e, m, y, d, r, c);
    end

    // Asynchronous reset with 6 entries and live inputs
    do_cycle(1'b0, mk_rand(), 1'b0, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 6; n++) do_cycle(1'b1, mk_rand(), 1'b0, 1'b0, 1'b0, 1'b0);
    fifo_if.fe_queue_v_i    = 1'b1;
    fifo_if.fe_queue_i      = mk_rand();
    fifo_if.fe_queue_yumi_i = 1'b1;
    #3;
    reset = 1'b1;
    #1;
    chk("arst_v_o", fifo_if.fe_queue_v_o, 1'b0);
    chk("arst_ready", fifo_if.fe_queue_ready_o, 1'b1);
    chk("arst_issue", fifo_if.issue_pkt_o, '0);
    chk("arst_preissue", fifo_if.preissue_pkt_o, '0);
    mq.delete();
    spec = 0;
    fifo_if.fe_queue_v_i    = 1'b0;
    fifo_if.fe_queue_yumi_i = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    idle();
    do_cycle(1'b1, mk_rand(), 1'b0, 1'b0, 1'b0, 1'b0);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bp_be_issue_ckpt_fifo.md
Name: bp_be_issue_ckpt_fifo

Overview:
- Checkpointed FIFO between the FE queue interface and the BE scheduler.
- Buffers FE queue messages (fetch or exception) and hands the head entry to the scheduler speculatively.
- Holds entries until commit, so a rollback can replay them and a clear can discard them.
- Predecodes each instruction on enqueue. It presents an issue packet for the current head, and a pre-issue packet for the next-cycle head so the synchronous register files can be read one cycle early.

Parameters:
- bp_params_p, e_bp_default_cfg, processor configuration. Supplies vaddr_width_p and branch_metadata_fwd_width_p.
- els_p, 8, entry count. Must be a power of two and at least 2.
- ptr_width_lp, `BSG_SAFE_CLOG2(els_p)+1, pointer width including the wrap bit (derived).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- clr_v_i  in  1  discard all uncommitted entries.
- deq_v_i  in  1  commit (retire) the oldest entry.
- roll_v_i  in  1  rewind speculative read pointer to commit pointer.
- fe_queue_i  in  fe_queue_width_lp  FE message.
- fe_queue_v_i  in  1  FE message valid.
- fe_queue_ready_o  out  1  space available; enqueue occurs on v&ready.
- fe_queue_o  out  fe_queue_width_lp  entry at read pointer.
- fe_queue_v_o  out  1  read pointer != write pointer.
- fe_queue_yumi_i  in  1  consume head; legal only when v_o.
- preissue_pkt_o  out  issue_pkt_width_lp  predecode of next-cycle head.
- issue_pkt_o  out  issue_pkt_width_lp  predecode of current head (registered).

Behaviour:
- Pointers:
  - wptr: enqueue.
  - rptr: speculative issue.
  - cptr: commit.
  - Each pointer is ptr_width_lp wide; the MSB is the wrap bit, and the low bits index storage.
- Reset state (asynchronous):
  - All pointers = 0.
  - fe_queue_v_o = 0, fe_queue_ready_o = 1.
  - issue_pkt_o = '0, preissue_pkt_o = '0.
  - Storage contents are don't-care.
- Full when wptr and cptr have equal low bits and differing MSB.
  - fe_queue_ready_o = ~full. It is combinational from state only, never from inputs.
- Enqueue on fe_queue_v_i & ready_o:
  - Writes the message plus its predecode at wptr.
  - wptr+1, wrapping naturally in ptr_width_lp bits.
- Next-state priority per cycle (evaluate in this order):
  - clr_v_i: wptr <= cptr_n, rptr <= cptr_n. Any enqueue in the same cycle is dropped.
  - else roll_v_i: rptr <= cptr_n. Any yumi in the same cycle is ignored.
  - else fe_queue_yumi_i: rptr+1.
  - Here cptr_n = cptr + deq_v_i. deq is applied in every case, including together with clr and roll.
- deq_v_i is legal only when cptr != rptr. The bench must check this with an assertion.
- fe_queue_o/fe_queue_v_o:
  - Driven combinationally from the storage read at rptr.
  - No bypass: an entry becomes visible one cycle after enqueue.
- issue_pkt_o: registered.
  - Loads the predecode of the next-cycle head entry (rptr_n) every cycle.
  - Equals the predecode of fe_queue_o whenever fe_queue_v_o = 1.
- preissue_pkt_o: combinational predecode at rptr_n.
  - If rptr_n == wptr and an enqueue is occurring this cycle (and no clr), bypass the predecode of fe_queue_i.
  - If the queue becomes empty next cycle, all valid bits are 0.
- Predecode, applied to e_fe_fetch messages only (exception messages yield all-zero valid bits):
  - rs1/rs2/rs3/rd addresses taken from the instruction fields.
  - irs1_v, irs2_v, frs1_v, frs2_v, frs3_v.
  - fence_v, csr_w_v, mem_v, long_v (mul/div/fp-div/sqrt).
- Wrap-around: pointer comparisons use the full width, so there is no ambiguity at els_p occupancy.
- Reset mid-operation: all state returns to reset values asynchronously. No partial writes persist visibly.

Decomposition:
- Place in bp_be_pkg:
  - bp_be_issue_pkt_s (via the existing internal-if struct macro).
  - Opcode constants used for predecode.
- Sub-module bp_be_issue_predecode: purely combinational, fe_queue message -> issue packet.
  - Instantiated twice: enqueue path and bypass path.
- Storage: bsg_mem_1r1w, asynchronous read, els_p entries.
  - Each entry = message + predecode.

Test Plan:
- Enqueue 3 fetches (ADD x3,x1,x2; LD x5,0(x6); FADD.D f1,f2,f3) with no yumi.
  - v_o rises 1 cycle after the first enqueue.
  - issue_pkt_o shows irs1_v=irs2_v=1, rs1=1, rs2=2.
  - preissue_pkt_o for the first enqueue (queue empty) bypasses: rs1=1 in the same cycle.
- Fill 8 entries with no deq: ready_o=0 after the 8th. Yumi all 8: ready_o stays 0. One deq: ready_o=1 the next cycle.
- Enqueue 4, yumi 3, deq 1, then roll.
  - rptr returns to entry 1 (0+1).
  - fe_queue_o = second message; issue_pkt_o matches it the next cycle.
- roll_v_i with yumi and deq in the same cycle: rptr = cptr+1; the yumi is ignored.
- clr_v_i with 5 entries (2 committed) and a simultaneous enqueue: v_o=0 and ready_o=1 the next cycle; the enqueued message never appears.
- Exception message (e_instr_page_fault) at head: all predecode valid bits 0.
- Assert reset_i mid-stream with 6 entries: outputs go to reset values without a clock edge.
